captura_operandos: RTL and testbench

Keypad operand-capture stage for the TP3 calculator: converts a stream of decoded key presses into two binary operands, an operation code and the enable strobes consumed directly downstream by `es_operacion`. It accumulates decimal digits into binary, tracks entry phase with a small FSM, and holds `igual_en` while a completed expression is presented for evaluation.

---
 rtl/captura_operandos_if.sv | 24 ++
 rtl/captura_operandos.sv | 152 +++++++++++++++
 tb/tb_captura_operandos.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/captura_operandos_if.sv
// Key-entry and operand-output bundle between the keypad decoder, the capture stage and es_operacion.
interface captura_operandos_if #(
  parameter int unsigned WIDTH = 16
);
  logic             key_valid;
  logic [3:0]       key_code;
  logic [WIDTH-1:0] numero_1;
  logic [WIDTH-1:0] numero_2;
  logic [1:0]       suma_resta;
  logic             operando_en;
  logic             igual_en;
  logic [WIDTH-1:0] display;
  logic [2:0]       digitos;

  modport master (
    output key_valid, key_code,
    input  numero_1, numero_2, suma_resta, operando_en, igual_en, display, digitos
  );

  modport slave (
    input  key_valid, key_code,
    output numero_1, numero_2, suma_resta, operando_en, igual_en, display, digitos
  );
endinterface

// File: rtl/captura_operandos.sv
// Keypad operand capture: accumulates decimal digits into two binary operands plus an operator,
// and raises igual_en while a complete expression is held for evaluation.
module captura_operandos #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  captura_operandos_if.slave   bus
);

  localparam int unsigned EW = WIDTH + 4;
  localparam logic [2:0]  MAX_CNT = 3'(MAX_DIGITS);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] num_a;
  logic [WIDTH-1:0] num_b;
  logic [1:0]       op;
  logic [2:0]       count_a;
  logic [2:0]       count_b;
  logic             op_en;
  logic             eq_en;
  logic [WIDTH-1:0] disp;
  logic [2:0]       digs;

  logic             is_digit;
  logic             is_oper;
  logic             is_eq;
  logic             is_clr;
  logic [1:0]       oper_code;
  logic [EW-1:0]    digit_ext;
  logic [WIDTH-1:0] mac_a;
  logic [WIDTH-1:0] mac_b;

  // Key decode and acc*10+d via shift-add, in a wider field then truncated.
  always_comb begin
    is_digit  = 1'b0;
    is_oper   = 1'b0;
    is_eq     = 1'b0;
    is_clr    = 1'b0;
    oper_code = 2'd0;
    digit_ext = EW'(key_code_dec());
    mac_a     = '0;
    mac_b     = '0;

    is_digit  = (bus.key_code <= 4'd9);
    is_oper   = (bus.key_code == 4'd10) || (bus.key_code == 4'd11);
    is_eq     = (bus.key_code == 4'd12);
    is_clr    = (bus.key_code == 4'd13);
    oper_code = (bus.key_code == 4'd10) ? 2'd1 : 2'd2;
    mac_a     = WIDTH'((EW'(num_a) << 3) + (EW'(num_a) << 1) + digit_ext);
    mac_b     = WIDTH'((EW'(num_b) << 3) + (EW'(num_b) << 1) + digit_ext);
  end

  function automatic logic [3:0] key_code_dec();
    return bus.key_code;
  endfunction

  // Entry-phase FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ENTER_A;
      num_a   <= '0;
      num_b   <= '0;
      op      <= 2'd0;
      count_a <= 3'd0;
      count_b <= 3'd0;
      op_en   <= 1'b0;
      eq_en   <= 1'b0;
      disp    <= '0;
      digs    <= 3'd0;
    end else begin
      op_en <= 1'b0;
      if (bus.key_valid) begin
        if (is_clr) begin
          state   <= ENTER_A;
          num_a   <= '0;
          num_b   <= '0;
          op      <= 2'd0;
          count_a <= 3'd0;
          count_b <= 3'd0;
          eq_en   <= 1'b0;
          disp    <= '0;
          digs    <= 3'd0;
        end else begin
          unique case (state)
            ENTER_A: begin
              if (is_digit && (count_a < MAX_CNT)) begin
                num_a   <= mac_a;
                count_a <= count_a + 3'd1;
                disp    <= mac_a;
                digs    <= count_a + 3'd1;
              end else if (is_oper) begin
                op      <= oper_code;
                op_en   <= 1'b1;
                num_b   <= '0;
                count_b <= 3'd0;
                disp    <= '0;
                digs    <= 3'd0;
                state   <= ENTER_B;
              end
            end
            ENTER_B: begin
              if (is_digit && (count_b < MAX_CNT)) begin
                num_b   <= mac_b;
                count_b <= count_b + 3'd1;
                disp    <= mac_b;
                digs    <= count_b + 3'd1;
              end else if (is_oper && (count_b == 3'd0)) begin
                op    <= oper_code;
                op_en <= 1'b1;
              end else if (is_eq && (count_b != 3'd0)) begin
                eq_en <= 1'b1;
                state <= DONE;
              end
            end
            DONE: begin
              // A new digit starts a fresh expression with that digit as operand A.
              if (is_digit) begin
                num_a   <= WIDTH'(bus.key_code);
                count_a <= 3'd1;
                num_b   <= '0;
                count_b <= 3'd0;
                op      <= 2'd0;
                eq_en   <= 1'b0;
                disp    <= WIDTH'(bus.key_code);
                digs    <= 3'd1;
                state   <= ENTER_A;
              end
            end
            default: state <= ENTER_A;
          endcase
        end
      end
    end
  end

  assign bus.numero_1    = num_a;
  assign bus.numero_2    = num_b;
  assign bus.suma_resta  = op;
  assign bus.operando_en = op_en;
  assign bus.igual_en    = eq_en;
  assign bus.display     = disp;
  assign bus.digitos     = digs;

endmodule

// File: tb/tb_captura_operandos.sv
// Directed bench for captura_operandos: key sequences with hand-computed operands, op and strobes.
module tb_captura_operandos;

  localparam int unsigned WIDTH = 16;

  logic clk;
  logic reset;
  int unsigned checks;
  int unsigned errors;

  captura_operandos_if #(.WIDTH(WIDTH)) bus ();

  captura_operandos #(.WIDTH(WIDTH), .MAX_DIGITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One key strobe for one cycle, then verify the operator pulse it should (or should not) cause.
  task automatic press(input logic [3:0] code, input int unsigned exp_pulse);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
    check($sformatf("operando_en key %0d", code), int'(bus.operando_en), exp_pulse);
  endtask

  task automatic check_all(input string tag, input int unsigned n1, input int unsigned n2,
                           input int unsigned op, input int unsigned ig,
                           input int unsigned disp, input int unsigned dig);
    check({tag, " numero_1"},   int'(bus.numero_1),   n1);
    check({tag, " numero_2"},   int'(bus.numero_2),   n2);
    check({tag, " suma_resta"}, int'(bus.suma_resta), op);
    check({tag, " igual_en"},   int'(bus.igual_en),   ig);
    check({tag, " display"},    int'(bus.display),    disp);
    check({tag, " digitos"},    int'(bus.digitos),    dig);
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < int'(n); i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    clk           = 1'b0;
    reset         = 1'b0;
    checks        = 0;
    errors        = 0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'd0;

    idle(2);
    check_all("reset", 0, 0, 0, 0, 0, 0);
    check("reset operando_en", int'(bus.operando_en), 0);
    @(negedge clk);
    reset = 1'b1;

    // Ignored codes from reset, then a non-strobed digit.
    press(4'd14, 0);
    press(4'd15, 0);
    press(4'd12, 0);
    @(negedge clk);
    bus.key_code = 4'd3;
    idle(2);
    check_all("ignored", 0, 0, 0, 0, 0, 0);

    // 123 + 45 =
    press(4'd1, 0);
    press(4'd2, 0);
    press(4'd3, 0);
    check_all("A=123", 123, 0, 0, 0, 123, 3);
    press(4'd10, 1);
    check_all("after +", 123, 0, 1, 0, 0, 0);
    press(4'd4, 0);
    press(4'd5, 0);
    press(4'd12, 0);
    check_all("123+45=", 123, 45, 1, 1, 45, 2);
    idle(3);
    check("held operando_en", int'(bus.operando_en), 0);
    press(4'd10, 0);
    check_all("DONE ignores +", 123, 45, 1, 1, 45, 2);

    // 9999 - 1 =, fifth 9 rejected
    press(4'd13, 0);
    check_all("clear", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) press(4'd9, 0);
    check_all("A=9999", 9999, 0, 0, 0, 9999, 4);
    press(4'd11, 1);
    press(4'd1, 0);
    press(4'd12, 0);
    check_all("9999-1=", 9999, 1, 2, 1, 1, 1);

    // 7 + - 3 + =: operator replaced before B digit, ignored after
    press(4'd13, 0);
    press(4'd7, 0);
    press(4'd10, 1);
    press(4'd12, 0);
    check("early = igual_en", int'(bus.igual_en), 0);
    press(4'd11, 1);
    check("replaced op", int'(bus.suma_resta), 2);
    press(4'd3, 0);
    press(4'd10, 0);
    press(4'd12, 0);
    check_all("7-3=", 7, 3, 2, 1, 3, 1);

    // 5 + 6 = then 8 starts a new expression
    press(4'd13, 0);
    press(4'd5, 0);
    press(4'd10, 1);
    press(4'd6, 0);
    press(4'd12, 0);
    check_all("5+6=", 5, 6, 1, 1, 6, 1);
    press(4'd8, 0);
    check_all("restart 8", 8, 0, 0, 0, 8, 1);
    press(4'd12, 0);
    check_all("= after restart", 8, 0, 0, 0, 8, 1);

    // Clear after operator
    press(4'd4, 0);
    press(4'd2, 0);
    press(4'd10, 1);
    press(4'd13, 0);
    check_all("42+clear", 0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid ENTER_B, between clock edges
    press(4'd4, 0);
    press(4'd10, 1);
    press(4'd7, 0);
    check_all("4+7 pending", 4, 7, 1, 0, 7, 1);
    #2;
    reset = 1'b0;
    #1;
    check_all("async reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    press(4'd1, 0);
    press(4'd10, 1);
    press(4'd1, 0);
    press(4'd12, 0);
    check_all("1+1=", 1, 1, 1, 1, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
